// File: rtl/baud_tick_gen_pkg.sv
// Shared definitions for the fractional baud tick generator.
//  - state_e       : controller states (IDLE / RUN / DONE)
//  - MODE_*        : encoding of the mode input (periodic or one-shot)
//  - MIN_DIV       : smallest integer divisor the counter can honour
package baud_tick_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/baud_tick_gen_frac_accum.sv
// Fractional phase accumulator for the baud tick generator.
// Each advance adds step_i to a FRAC_BITS-wide accumulator; the overflow of
// that addition is held in carry_o and stretches the *next* period by one
// cycle. clear_i has priority over advance_i.
// Ports:
//  clk_i      clock, rising edge
//  reset_i    synchronous active-high reset
//  clear_i    zero accumulator and carry
//  advance_i  accumulate step_i (one oversample terminal count)
//  step_i     fractional step F
//  carry_o    registered carry, 1 = next period is one cycle longer
module baud_tick_gen_frac_accum
    import baud_tick_gen_pkg::*;
#(
    parameter int FRAC_BITS = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 clear_i,
    input  logic                 advance_i,
    input  logic [FRAC_BITS-1:0] step_i,
    output logic                 carry_o
);

    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic                 carry_q, carry_d;

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        if (clear_i) begin
            acc_d   = '0;
            carry_d = 1'b0;
        end else if (advance_i) begin
            {carry_d, acc_d} = {1'b0, acc_q} + {1'b0, step_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign carry_o = carry_q;

endmodule

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator.
// Divides clk_i by N + F/2^FRAC_BITS to produce ovs_tick_o, and every
// OVS_RATIO-th oversample tick also raises bit_tick_o. Divisors and mode are
// shadowed on restart and on every oversample terminal count, so a runtime
// divisor change only takes effect from the next period.
// Ports:
//  clk_i       clock, rising edge
//  reset_i     synchronous active-high reset
//  enable_i    1 = counters advance, 0 = freeze
//  restart_i   clear counters, reload divisors, enter RUN
//  mode_i      0 = periodic, 1 = one-shot (stop after first bit tick)
//  div_int_i   integer divisor N (2 .. 2^INT_BITS-1)
//  div_frac_i  fractional divisor F
//  ovs_tick_o  1-cycle pulse per oversample period
//  bit_tick_o  1-cycle pulse with every OVS_RATIO-th ovs_tick_o
//  busy_o      1 while running
//  cfg_err_o   1 while the shadowed integer divisor is below 2
module baud_tick_gen
    import baud_tick_gen_pkg::*;
#(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 4,
    parameter int OVS_RATIO = 16
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic                 restart_i,
    input  logic                 mode_i,
    input  logic [INT_BITS-1:0]  div_int_i,
    input  logic [FRAC_BITS-1:0] div_frac_i,
    output logic                 ovs_tick_o,
    output logic                 bit_tick_o,
    output logic                 busy_o,
    output logic                 cfg_err_o
);

    localparam int                  OVS_W     = $clog2(OVS_RATIO);
    localparam logic [OVS_W-1:0]    OVS_LAST  = OVS_W'(OVS_RATIO - 1);
    localparam logic [OVS_W-1:0]    OVS_ONE   = OVS_W'(1);
    localparam logic [INT_BITS:0]   CNT_ONE   = (INT_BITS + 1)'(1);
    localparam logic [INT_BITS-1:0] MIN_DIV_V = INT_BITS'(MIN_DIV);

    state_e                state_q;
    logic [INT_BITS:0]     cnt_q;
    logic [OVS_W-1:0]      ovs_cnt_q;
    logic [INT_BITS-1:0]   int_sh_q;
    logic [FRAC_BITS-1:0]  frac_sh_q;
    logic                  mode_sh_q;
    logic                  ovs_tick_q;
    logic                  bit_tick_q;
    logic                  cfg_err_q;

    logic                  carry;
    logic [INT_BITS:0]     last_cnt;
    logic                  run_step;
    logic                  at_term;
    logic                  bit_term;

    // Carry from the previous period lengthens this one: P = int_sh + carry.
    // restart_i blocks counting so a restart on a terminal cycle emits no tick.
    always_comb begin
        last_cnt = {1'b0, int_sh_q} + {{INT_BITS{1'b0}}, carry} - CNT_ONE;
        run_step = (state_q == ST_RUN) && enable_i && !cfg_err_q && !restart_i;
        at_term  = run_step && (cnt_q == last_cnt);
        bit_term = at_term && (ovs_cnt_q == OVS_LAST);
    end

    baud_tick_gen_frac_accum #(
        .FRAC_BITS (FRAC_BITS)
    ) u_frac_accum (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (restart_i),
        .advance_i (at_term),
        .step_i    (frac_sh_q),
        .carry_o   (carry)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ovs_cnt_q  <= '0;
            int_sh_q   <= '0;
            frac_sh_q  <= '0;
            mode_sh_q  <= MODE_PERIODIC;
            ovs_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            ovs_tick_q <= 1'b0;
            bit_tick_q <= 1'b0;
            if (restart_i) begin
                state_q   <= ST_RUN;
                cnt_q     <= '0;
                ovs_cnt_q <= '0;
                int_sh_q  <= div_int_i;
                frac_sh_q <= div_frac_i;
                mode_sh_q <= mode_i;
                cfg_err_q <= (div_int_i < MIN_DIV_V);
            end else if (at_term) begin
                cnt_q      <= '0;
                ovs_tick_q <= 1'b1;
                bit_tick_q <= bit_term;
                ovs_cnt_q  <= bit_term ? '0 : ovs_cnt_q + OVS_ONE;
                // New divisors apply from the next period only.
                int_sh_q   <= div_int_i;
                frac_sh_q  <= div_frac_i;
                mode_sh_q  <= mode_i;
                cfg_err_q  <= (div_int_i < MIN_DIV_V);
                // Decision uses the mode that was shadowed for this bit.
                if (bit_term && (mode_sh_q == MODE_ONESHOT)) begin
                    state_q <= ST_DONE;
                end
            end else if (run_step) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    assign ovs_tick_o = ovs_tick_q;
    assign bit_tick_o = bit_tick_q;
    assign busy_o     = (state_q == ST_RUN);
    assign cfg_err_o  = cfg_err_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
module tb_baud_tick_gen;

    localparam int FRAC_ONE = 16;   // 2^FRAC_BITS
    localparam int OVS      = 16;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        restart;
    logic        mode;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        ovs_tick_o;
    logic        bit_tick_o;
    logic        busy_o;
    logic        cfg_err_o;

    baud_tick_gen dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .enable_i   (enable),
        .restart_i  (restart),
        .mode_i     (mode),
        .div_int_i  (div_int),
        .div_frac_i (div_frac),
        .ovs_tick_o (ovs_tick_o),
        .bit_tick_o (bit_tick_o),
        .busy_o     (busy_o),
        .cfg_err_o  (cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    int exp_ovs[$];
    int exp_bit[$];
    int obs_ovs[$];
    int obs_bit[$];
    bit cur_os = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: every observed tick must match the head of its queue.
    always @(negedge clk) begin
        int e;
        if (ovs_tick_o) begin
            obs_ovs.push_back(cyc);
            if (exp_ovs.size() == 0) check("ovs_unexpected_cycle", cyc, -1);
            else begin
                e = exp_ovs.pop_front();
                check("ovs_tick_cycle", cyc, e);
            end
        end
        if (bit_tick_o) begin
            obs_bit.push_back(cyc);
            check("busy_at_bit", int'(busy_o), cur_os ? 0 : 1);
            if (exp_bit.size() == 0) check("bit_unexpected_cycle", cyc, -1);
            else begin
                e = exp_bit.pop_front();
                check("bit_tick_cycle", cyc, e);
            end
        end
    end

    // Period j after restart: N plus the carry produced by the (j-1)-th
    // accumulation, i.e. floor((j-1)F/2^FB) - floor((j-2)F/2^FB).
    function automatic int period(input int n, input int f, input int j);
        if (j == 1) return n;
        return n + ((j - 1) * f) / FRAC_ONE - ((j - 2) * f) / FRAC_ONE;
    endfunction

    task automatic push_seg(input int r, input int n, input int f, input int len, input bit os);
        int t;
        t = r;
        for (int j = 1; j <= 4096; j++) begin
            t += period(n, f, j);
            if (t > r + len) break;
            exp_ovs.push_back(t);
            if (j % OVS == 0) begin
                exp_bit.push_back(t);
                if (os) break;
            end
        end
    endtask

    // All stimulus runs 1 time unit after a falling edge.
    task automatic tick_n(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick_n(1);
    endtask

    task automatic do_restart(input int n, input int f, input bit os, output int r);
        div_int  = 16'(n);
        div_frac = 4'(f);
        mode     = os;
        cur_os   = os;
        restart  = 1'b1;
        tick_n(1);
        restart  = 1'b0;
        r        = cyc;
        obs_ovs.delete();
        obs_bit.delete();
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_ovs_missing"}, exp_ovs.size(), 0);
        check({tag, "_bit_missing"}, exp_bit.size(), 0);
        exp_ovs.delete();
        exp_bit.delete();
    endtask

    typedef struct {
        int n;
        int f;
        bit os;
        int len;
        int first_bit;  // cycles from restart to first bit tick
        int span;       // ovs tick 1 to ovs tick 17, 0 = not applicable
        bit busy_end;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int r;
        int r2;

        vecs[0] = '{4, 0,  1'b0, 140, 64,  64,  1'b1};
        vecs[1] = '{5, 8,  1'b0, 200, 87,  88,  1'b1};
        vecs[2] = '{2, 0,  1'b1, 232, 32,  0,   1'b0};
        vecs[3] = '{3, 5,  1'b0, 120, 52,  53,  1'b1};
        vecs[4] = '{7, 15, 1'b0, 200, 126, 127, 1'b1};
        vecs[5] = '{2, 0,  1'b1, 232, 32,  0,   1'b0};

        reset    = 1'b1;
        enable   = 1'b1;
        restart  = 1'b0;
        mode     = 1'b0;
        div_int  = 16'd4;
        div_frac = 4'd0;
        tick_n(3);
        check("reset_ovs_tick", int'(ovs_tick_o), 0);
        check("reset_bit_tick", int'(bit_tick_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_cfg_err", int'(cfg_err_o), 0);
        reset = 1'b0;
        tick_n(10);
        check("idle_busy", int'(busy_o), 0);
        check("idle_cfg_err", int'(cfg_err_o), 0);
        $display("reset/idle: busy=%0d cfg_err=%0d", busy_o, cfg_err_o);

        // Table-driven segments.
        for (int i = 0; i < 6; i++) begin
            do_restart(vecs[i].n, vecs[i].f, vecs[i].os, r);
            check("busy_after_restart", int'(busy_o), 1);
            push_seg(r, vecs[i].n, vecs[i].f, vecs[i].len, vecs[i].os);
            tick_n(vecs[i].len);
            check("first_bit_latency", (obs_bit.size() > 0) ? obs_bit[0] - r : -1, vecs[i].first_bit);
            if (vecs[i].span > 0)
                check("span_16_ovs", (obs_ovs.size() > 16) ? obs_ovs[16] - obs_ovs[0] : -1, vecs[i].span);
            check("busy_end", int'(busy_o), vecs[i].busy_end ? 1 : 0);
            check_drained("seg");
            $display("seg %0d: N=%0d F=%0d oneshot=%0d ovs_ticks=%0d bit_ticks=%0d",
                     i, vecs[i].n, vecs[i].f, vecs[i].os, obs_ovs.size(), obs_bit.size());
        end

        // Divisor change mid-period: current period keeps N=10, then 3.
        do_restart(10, 0, 1'b0, r);
        exp_ovs.push_back(r + 10);
        exp_ovs.push_back(r + 20);
        exp_ovs.push_back(r + 23);
        exp_ovs.push_back(r + 26);
        exp_ovs.push_back(r + 29);
        wait_until(r + 14);
        div_int = 16'd3;
        wait_until(r + 30);
        check_drained("divchg");
        $display("divchg: N 10->3 mid-period, ovs_ticks=%0d", obs_ovs.size());

        // Enable low for 7 cycles stretches one period 8 -> 15; then reset.
        do_restart(8, 0, 1'b0, r);
        exp_ovs.push_back(r + 8);
        exp_ovs.push_back(r + 23);
        exp_ovs.push_back(r + 31);
        wait_until(r + 11);
        enable = 1'b0;
        wait_until(r + 15);
        check("busy_while_disabled", int'(busy_o), 1);
        wait_until(r + 18);
        enable = 1'b1;
        wait_until(r + 38);
        check("busy_before_reset", int'(busy_o), 1);
        reset = 1'b1;
        tick_n(1);
        check("midrun_reset_ovs", int'(ovs_tick_o), 0);
        check("midrun_reset_bit", int'(bit_tick_o), 0);
        check("midrun_reset_busy", int'(busy_o), 0);
        check("midrun_reset_cfg_err", int'(cfg_err_o), 0);
        reset = 1'b0;
        tick_n(20);
        check("idle_after_reset_busy", int'(busy_o), 0);
        check_drained("enable");
        $display("enable/reset: ovs_ticks=%0d", obs_ovs.size());

        // Invalid divisor, then valid divisor, then restart on terminal count.
        do_restart(1, 0, 1'b0, r);
        check("cfg_err_set", int'(cfg_err_o), 1);
        wait_until(r + 100);
        check_drained("cfgerr");
        do_restart(3, 0, 1'b0, r);
        check("cfg_err_clear", int'(cfg_err_o), 0);
        exp_ovs.push_back(r + 3);
        exp_ovs.push_back(r + 6);
        wait_until(r + 8);
        do_restart(3, 0, 1'b0, r2);
        check("restart_at_term_cycle", r2, r + 9);
        check("restart_at_term_no_tick", int'(ovs_tick_o), 0);
        exp_ovs.push_back(r2 + 3);
        exp_ovs.push_back(r2 + 6);
        wait_until(r2 + 6);
        check_drained("termrst");
        $display("cfg_err/term restart: ovs_ticks after restart=%0d", obs_ovs.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
